// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: buffer bases, byte lanes, writer FSM states, pixel word fields.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package fb_pkg;

  localparam logic [28:0] FB0_BASE_DEFAULT = 29'h0700_0000;
  localparam logic [28:0] FB1_BASE_DEFAULT = 29'h0702_5800;

  // Byte lanes of a 64-bit word holding two 32-bit pixels: even x low, odd x high.
  localparam logic [7:0] BE_EVEN = 8'h0F;
  localparam logic [7:0] BE_ODD  = 8'hF0;
  localparam logic [7:0] BE_FULL = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_COLLECT = 4'd1,
    ST_PIX_WR  = 4'd2,
    ST_FILL_WR = 4'd3
  } fb_state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] colour;
  } pixel_t;

  function automatic logic [15:0] pix_x(input logic [63:0] d);
    return d[63:48];
  endfunction

  function automatic logic [15:0] pix_y(input logic [63:0] d);
    return d[47:32];
  endfunction

  function automatic logic [31:0] pix_colour(input logic [63:0] d);
    return d[31:0];
  endfunction

  // Word offset of a pixel inside a buffer; two pixels share one 64-bit word.
  function automatic logic [31:0] pix_word_offset(input logic [15:0] x, input logic [15:0] y,
                                                  input int unsigned width);
    logic [31:0] lin;
    lin = 32'(y) * width + 32'(x);
    return lin >> 1;
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Single-clock show-ahead FIFO: head shows the oldest entry whenever empty is low.
// Latency: a push is visible at head the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module fb_pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Flags, guarded handshakes and next pointers; extra pointer bit separates full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    head     = mem[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/framebuffer_write_burst.sv
// Pixel writer to the DDR3 framebuffer: clips, merges even/odd pairs, and burst-fills a buffer.
// Latency: write asserted 1-2 cycles after a pixel is popped from the FIFO; fill starts next cycle.
// Backpressure: pixel_ready low when FIFO full or fill busy; all Avalon outputs held under waitrequest.
module framebuffer_write_burst
  import fb_pkg::*;
#(
  parameter int unsigned       FB_WIDTH   = 640,
  parameter int unsigned       FB_HEIGHT  = 480,
  parameter int unsigned       ADDR_W     = 29,
  parameter logic [ADDR_W-1:0] FB0_BASE   = ADDR_W'(FB0_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] FB1_BASE   = ADDR_W'(FB1_BASE_DEFAULT),
  parameter int unsigned       MAX_BURST  = 8,
  parameter int unsigned       FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        burstcount,
  output logic [7:0]        byteenable,
  output logic [63:0]       writedata,
  output logic              write,
  input  logic              waitrequest,
  input  logic              buffer,
  input  logic              fill_background,
  input  logic [31:0]       background_colour,
  input  logic [63:0]       pixel_data,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  output logic              fill_busy,
  output logic [15:0]       drop_count,
  output logic [3:0]        state
);

  localparam int unsigned TOTAL_WORDS = FB_WIDTH * FB_HEIGHT / 2;
  localparam logic [7:0]  FIRST_BURST = 8'((TOTAL_WORDS >= MAX_BURST) ? MAX_BURST : TOTAL_WORDS);
  localparam logic [31:0] FIRST_LEFT  = 32'(TOTAL_WORDS) - 32'(FIRST_BURST);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [7:0]        burstcount_q, burstcount_d;
  logic [7:0]        byteenable_q, byteenable_d;
  logic [63:0]       writedata_q, writedata_d;
  logic              write_q, write_d;
  logic              fill_busy_q, fill_busy_d;
  logic              fill_req_q, fill_req_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic [15:0]       held_x_q, held_x_d;
  logic [15:0]       held_y_q, held_y_d;
  logic [7:0]        beats_left_q, beats_left_d;
  logic [31:0]       words_left_q, words_left_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [63:0]       fifo_head;
  pixel_t            head_pix;
  logic              push_acc, in_frame, merge_ok;
  logic [ADDR_W-1:0] base_sel, head_addr;
  logic [7:0]        next_burst;

  assign pixel_ready = !fifo_full && !fill_busy_q;
  assign head_pix    = pixel_t'(fifo_head);
  assign base_sel    = buffer ? FB1_BASE : FB0_BASE;
  assign head_addr   = base_sel + ADDR_W'(pix_word_offset(head_pix.x, head_pix.y, FB_WIDTH));
  assign next_burst  = (words_left_q >= 32'(MAX_BURST)) ? 8'(MAX_BURST) : words_left_q[7:0];
  // FB_WIDTH is even, so x+1 of an even x always lands in the same word.
  assign merge_ok    = !fifo_empty && (head_pix.x == held_x_q + 16'd1) && (head_pix.y == held_y_q);

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (pixel_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Clip at push: out-of-frame pixels never enter the FIFO and bump the saturating drop counter.
  always_comb begin
    push_acc     = pixel_valid && pixel_ready;
    in_frame     = (32'(pix_x(pixel_data)) < FB_WIDTH) && (32'(pix_y(pixel_data)) < FB_HEIGHT);
    fifo_push    = push_acc && in_frame;
    drop_count_d = drop_count_q;
    if (push_acc && !in_frame && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  // Writer FSM next state; Avalon outputs are computed here and registered below.
  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    write_d      = write_q;
    fill_busy_d  = fill_busy_q;
    held_x_d     = held_x_q;
    held_y_d     = held_y_q;
    beats_left_d = beats_left_q;
    words_left_d = words_left_q;
    fifo_pop     = 1'b0;
    // A fill request arriving mid pixel write is remembered until the FSM is back in IDLE.
    fill_req_d   = fill_req_q || (fill_background && !fill_busy_q);

    case (state_q)
      ST_IDLE: begin
        if (fill_req_d) begin
          fill_req_d   = 1'b0;
          address_d    = base_sel;
          burstcount_d = FIRST_BURST;
          beats_left_d = FIRST_BURST;
          words_left_d = FIRST_LEFT;
          byteenable_d = BE_FULL;
          writedata_d  = {background_colour, background_colour};
          write_d      = 1'b1;
          fill_busy_d  = 1'b1;
          state_d      = ST_FILL_WR;
        end else if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          address_d    = head_addr;
          burstcount_d = 8'd1;
          if (head_pix.x[0]) begin
            byteenable_d = BE_ODD;
            writedata_d  = {head_pix.colour, 32'h0};
            write_d      = 1'b1;
            state_d      = ST_PIX_WR;
          end else begin
            byteenable_d = BE_EVEN;
            writedata_d  = {32'h0, head_pix.colour};
            held_x_d     = head_pix.x;
            held_y_d     = head_pix.y;
            state_d      = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (merge_ok) begin
          fifo_pop            = 1'b1;
          byteenable_d        = BE_FULL;
          writedata_d[63:32]  = head_pix.colour;
        end
        write_d = 1'b1;
        state_d = ST_PIX_WR;
      end

      ST_PIX_WR: begin
        if (!waitrequest) begin
          write_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_FILL_WR: begin
        if (!waitrequest) begin
          if (beats_left_q == 8'd1) begin
            if (words_left_q == 32'd0) begin
              write_d      = 1'b0;
              fill_busy_d  = 1'b0;
              burstcount_d = 8'd1;
              state_d      = ST_IDLE;
            end else begin
              // Next burst starts right after the one just completed; write stays high.
              address_d    = address_q + ADDR_W'(burstcount_q);
              burstcount_d = next_burst;
              beats_left_d = next_burst;
              words_left_d = words_left_q - 32'(next_burst);
            end
          end else begin
            beats_left_d = beats_left_q - 8'd1;
          end
        end
      end

      default: begin
        write_d     = 1'b0;
        fill_busy_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // All state and registered outputs; reset aborts any transaction immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      address_q    <= '0;
      burstcount_q <= 8'd1;
      byteenable_q <= 8'h00;
      writedata_q  <= 64'h0;
      write_q      <= 1'b0;
      fill_busy_q  <= 1'b0;
      fill_req_q   <= 1'b0;
      drop_count_q <= 16'h0;
      held_x_q     <= 16'h0;
      held_y_q     <= 16'h0;
      beats_left_q <= 8'd0;
      words_left_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      write_q      <= write_d;
      fill_busy_q  <= fill_busy_d;
      fill_req_q   <= fill_req_d;
      drop_count_q <= drop_count_d;
      held_x_q     <= held_x_d;
      held_y_q     <= held_y_d;
      beats_left_q <= beats_left_d;
      words_left_q <= words_left_d;
    end
  end

  assign address    = address_q;
  assign burstcount = burstcount_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;
  assign write      = write_q;
  assign fill_busy  = fill_busy_q;
  assign drop_count = drop_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_framebuffer_write_burst.sv
// Bench for framebuffer_write_burst: full-size instance for pixel paths, 6x3 instance for fills.
// Expected Avalon beats are queued as stimulus is driven and compared every cycle write is high.
// Random waitrequest exercises output holding; reset is asserted mid-transaction at the end.
module tb_framebuffer_write_burst;

  typedef struct packed {
    logic [28:0] addr;
    logic [7:0]  bc;
    logic [7:0]  be;
    logic [63:0] data;
  } beat_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Full-size instance
  logic [28:0] b_address;
  logic [7:0]  b_burstcount, b_byteenable;
  logic [63:0] b_writedata, b_pix;
  logic        b_write, b_waitrequest, b_buffer, b_fill, b_pix_vld, b_pix_rdy, b_fill_busy;
  logic [31:0] b_bg;
  logic [15:0] b_drop;
  logic [3:0]  b_state;
  // Small instance (6x3 frame, bursts of 4)
  logic [28:0] s_address;
  logic [7:0]  s_burstcount, s_byteenable;
  logic [63:0] s_writedata, s_pix;
  logic        s_write, s_waitrequest, s_buffer, s_fill, s_pix_vld, s_pix_rdy, s_fill_busy;
  logic [31:0] s_bg;
  logic [15:0] s_drop;
  logic [3:0]  s_state;

  logic b_wr_rand = 1'b0, b_wr_force = 1'b0, s_wr_rand = 1'b0;

  beat_t b_exp[$];
  beat_t s_exp[$];
  int    b_beats = 0, s_beats = 0;
  int    n_checks = 0, n_pass = 0;

  framebuffer_write_burst dut (
    .clock(clock), .reset_n(reset_n), .address(b_address), .burstcount(b_burstcount),
    .byteenable(b_byteenable), .writedata(b_writedata), .write(b_write),
    .waitrequest(b_waitrequest), .buffer(b_buffer), .fill_background(b_fill),
    .background_colour(b_bg), .pixel_data(b_pix), .pixel_valid(b_pix_vld),
    .pixel_ready(b_pix_rdy), .fill_busy(b_fill_busy), .drop_count(b_drop), .state(b_state)
  );

  framebuffer_write_burst #(.FB_WIDTH(6), .FB_HEIGHT(3), .MAX_BURST(4)) dut_s (
    .clock(clock), .reset_n(reset_n), .address(s_address), .burstcount(s_burstcount),
    .byteenable(s_byteenable), .writedata(s_writedata), .write(s_write),
    .waitrequest(s_waitrequest), .buffer(s_buffer), .fill_background(s_fill),
    .background_colour(s_bg), .pixel_data(s_pix), .pixel_valid(s_pix_vld),
    .pixel_ready(s_pix_rdy), .fill_busy(s_fill_busy), .drop_count(s_drop), .state(s_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic beat_t pix_beat(input logic [28:0] base, input int w, input int x,
                                     input int y, input logic [31:0] c);
    beat_t t;
    t.addr = base + 29'((y * w + x) / 2);
    t.bc   = 8'd1;
    if (x % 2 == 1) begin
      t.be   = 8'hF0;
      t.data = {c, 32'h0};
    end else begin
      t.be   = 8'h0F;
      t.data = {32'h0, c};
    end
    return t;
  endfunction

  // Expected fill of the 6x3 frame: 9 words cut into bursts of at most 4.
  task automatic queue_fill_s(input logic [28:0] base, input logic [31:0] c);
    int rem;
    int n;
    logic [28:0] a;
    rem = 9;
    a   = base;
    while (rem > 0) begin
      n = (rem > 4) ? 4 : rem;
      for (int i = 0; i < n; i++) s_exp.push_back({a, 8'(n), 8'hFF, {c, c}});
      a   = a + 29'(n);
      rem = rem - n;
    end
  endtask

  // Waitrequest drivers, changing just after each rising edge.
  initial begin
    b_waitrequest = 1'b0;
    s_waitrequest = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      b_waitrequest = b_wr_force ? 1'b1 : (b_wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0);
      s_waitrequest = s_wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // Scoreboards: while write is high the outputs must match the oldest expected beat.
  always @(negedge clock) begin
    if (reset_n && b_write) begin
      chk("b_write_expected", 64'(b_exp.size() != 0), 64'd1);
      if (b_exp.size() != 0) begin
        chk("b_address", 64'(b_address), 64'(b_exp[0].addr));
        chk("b_burstcount", 64'(b_burstcount), 64'(b_exp[0].bc));
        chk("b_byteenable", 64'(b_byteenable), 64'(b_exp[0].be));
        chk("b_writedata", b_writedata, b_exp[0].data);
        if (!b_waitrequest) begin
          void'(b_exp.pop_front());
          b_beats++;
        end
      end
    end
    if (reset_n && s_write) begin
      chk("s_write_expected", 64'(s_exp.size() != 0), 64'd1);
      if (s_exp.size() != 0) begin
        chk("s_address", 64'(s_address), 64'(s_exp[0].addr));
        chk("s_burstcount", 64'(s_burstcount), 64'(s_exp[0].bc));
        chk("s_byteenable", 64'(s_byteenable), 64'(s_exp[0].be));
        chk("s_writedata", s_writedata, s_exp[0].data);
        if (!s_waitrequest) begin
          void'(s_exp.pop_front());
          s_beats++;
        end
      end
    end
  end

  task automatic push_b(input int x, input int y, input logic [31:0] c);
    int n;
    n = 0;
    b_pix     = {16'(x), 16'(y), c};
    b_pix_vld = 1'b1;
    @(negedge clock);
    while (!b_pix_rdy && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("b_push_ready", 64'(b_pix_rdy), 64'd1);
    @(posedge clock);
    #1;
    b_pix_vld = 1'b0;
  endtask

  task automatic push_s(input int x, input int y, input logic [31:0] c);
    int n;
    n = 0;
    s_pix     = {16'(x), 16'(y), c};
    s_pix_vld = 1'b1;
    @(negedge clock);
    while (!s_pix_rdy && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("s_push_ready", 64'(s_pix_rdy), 64'd1);
    @(posedge clock);
    #1;
    s_pix_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (3) @(posedge clock);
    while ((b_exp.size() != 0 || s_exp.size() != 0 || b_state != 4'd0 || s_state != 4'd0)
           && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_pending", 64'(b_exp.size() + s_exp.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    b_buffer  = 1'b0; b_fill = 1'b0; b_bg = 32'h0; b_pix = 64'h0; b_pix_vld = 1'b0;
    s_buffer  = 1'b0; s_fill = 1'b0; s_bg = 32'h0; s_pix = 64'h0; s_pix_vld = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_write", 64'(b_write), 64'd0);
    chk("rst_address", 64'(b_address), 64'd0);
    chk("rst_burstcount", 64'(b_burstcount), 64'd1);
    chk("rst_byteenable", 64'(b_byteenable), 64'd0);
    chk("rst_writedata", b_writedata, 64'd0);
    chk("rst_fill_busy", 64'(b_fill_busy), 64'd0);
    chk("rst_drop_count", 64'(b_drop), 64'd0);
    chk("rst_state", 64'(b_state), 64'd0);
    chk("rst_pixel_ready", 64'(b_pix_rdy), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Pixel paths on the full-size frame with random stalls.
    b_wr_rand = 1'b1;
    b_exp.push_back({29'h0700_0281, 8'd1, 8'hF0, 64'hAABBCCDD_00000000});
    push_b(3, 2, 32'hAABB_CCDD);
    wait_idle(200);

    b_exp.push_back({29'h0700_0645, 8'd1, 8'hFF, {32'h3333_4444, 32'h1111_2222}});
    push_b(10, 5, 32'h1111_2222);
    push_b(11, 5, 32'h3333_4444);
    wait_idle(200);

    push_b(640, 0, 32'h0BAD_0001);
    push_b(0, 480, 32'h0BAD_0002);
    wait_idle(50);
    chk("drop_count_two", 64'(b_drop), 64'd2);
    b_exp.push_back({29'h0702_57FF, 8'd1, 8'hF0, 64'h7777_8888_0000_0000});
    push_b(639, 479, 32'h7777_8888);
    wait_idle(200);
    chk("drop_count_still_two", 64'(b_drop), 64'd2);

    b_buffer = 1'b1;
    b_exp.push_back({29'h0702_5800, 8'd1, 8'h0F, 64'h0000_0000_5A5A_5A5A});
    push_b(0, 0, 32'h5A5A_5A5A);
    wait_idle(200);
    b_buffer = 1'b0;

    // Non-adjacent, different-line and duplicate pairs stay half-word writes, in order.
    b_exp.push_back(pix_beat(29'h0700_0000, 640, 4, 1, 32'hC0C0_0004));
    b_exp.push_back(pix_beat(29'h0700_0000, 640, 7, 1, 32'hC0C0_0007));
    b_exp.push_back(pix_beat(29'h0700_0000, 640, 8, 2, 32'hC0C0_0008));
    b_exp.push_back(pix_beat(29'h0700_0000, 640, 9, 3, 32'hC0C0_0009));
    b_exp.push_back(pix_beat(29'h0700_0000, 640, 20, 0, 32'hAAAA_0001));
    b_exp.push_back(pix_beat(29'h0700_0000, 640, 20, 0, 32'hBBBB_0002));
    push_b(4, 1, 32'hC0C0_0004);
    push_b(7, 1, 32'hC0C0_0007);
    push_b(8, 2, 32'hC0C0_0008);
    push_b(9, 3, 32'hC0C0_0009);
    push_b(20, 0, 32'hAAAA_0001);
    push_b(20, 0, 32'hBBBB_0002);
    wait_idle(400);

    // Fill buffer 1 of the small frame with stalls; buffer/colour changes mid-fill are ignored.
    s_wr_rand = 1'b1;
    queue_fill_s(29'h0702_5800, 32'h1234_5678);
    s_buffer = 1'b1;
    s_bg     = 32'h1234_5678;
    s_fill   = 1'b1;
    @(posedge clock);
    #1;
    s_fill   = 1'b0;
    s_buffer = 1'b0;
    s_bg     = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("s_fill_busy_during", 64'(s_fill_busy), 64'd1);
    chk("s_ready_during_fill", 64'(s_pix_rdy), 64'd0);
    s_fill = 1'b1;
    @(posedge clock);
    #1;
    s_fill = 1'b0;
    s_exp.push_back(pix_beat(29'h0700_0000, 6, 5, 2, 32'hCAFE_F00D));
    push_s(5, 2, 32'hCAFE_F00D);
    wait_idle(300);
    chk("s_fill_busy_after", 64'(s_fill_busy), 64'd0);
    chk("s_beats_fill_plus_pixel", 64'(s_beats), 64'd10);

    // Second fill, buffer 0, no stalls.
    s_wr_rand = 1'b0;
    queue_fill_s(29'h0700_0000, 32'h0F0F_0F0F);
    s_bg   = 32'h0F0F_0F0F;
    s_fill = 1'b1;
    @(posedge clock);
    #1;
    s_fill = 1'b0;
    wait_idle(100);
    chk("s_beats_second_fill", 64'(s_beats), 64'd19);
    chk("s_burstcount_after_fill", 64'(s_burstcount), 64'd1);

    // Reset while a pixel write is stalled and another pixel waits in the FIFO.
    b_wr_rand  = 1'b0;
    b_wr_force = 1'b1;
    push_b(700, 0, 32'h0BAD_0003);
    b_exp.push_back(pix_beat(29'h0700_0000, 640, 1, 0, 32'h5555_AAAA));
    push_b(1, 0, 32'h5555_AAAA);
    push_b(2, 0, 32'h6666_BBBB);
    n = 0;
    @(negedge clock);
    while (!b_write && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("pre_reset_write", 64'(b_write), 64'd1);
    chk("pre_reset_drop", 64'(b_drop), 64'd3);
    #2;
    reset_n = 1'b0;
    b_exp.delete();
    #1;
    chk("mid_reset_write", 64'(b_write), 64'd0);
    chk("mid_reset_state", 64'(b_state), 64'd0);
    chk("mid_reset_drop", 64'(b_drop), 64'd0);
    chk("mid_reset_address", 64'(b_address), 64'd0);
    chk("mid_reset_byteenable", 64'(b_byteenable), 64'd0);
    b_wr_force = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("post_reset_state", 64'(b_state), 64'd0);
    chk("post_reset_ready", 64'(b_pix_rdy), 64'd1);
    chk("post_reset_no_beats", 64'(b_beats), 64'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
